// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_W_DEFAULT = 6;
    localparam int DIV_W_MAX     = 64;

    // Quotient reported on divide-by-zero; sliced to the operand width by users.
    localparam logic [DIV_W_MAX-1:0] DIV_Q_DBZ = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_e;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_sh  = {rem[WIDTH-1:0], dvd_msb};
        diff    = rem_sh - {1'b0, divisor};
        // Either top bit set means the shifted value already exceeds any WIDTH-bit divisor;
        // otherwise bit WIDTH of the difference is the borrow.
        q_bit   = rem[WIDTH] | rem_sh[WIDTH] | ~diff[WIDTH];
        rem_nxt = q_bit ? {1'b0, diff[WIDTH-1:0]} : {1'b0, rem_sh[WIDTH-1:0]};
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequential unsigned divider: one quotient bit per clock, done pulse when q/r are valid.
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;

    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic [WIDTH-1:0] quo_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .dvd_msb (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        quo_nxt = WIDTH'({quo_q, q_bit});
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (b != '0) begin
                        dvd_d   = a;
                        dsr_d   = b;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = CALC;
                    end else begin
                        // Divide-by-zero skips the datapath and reports immediately.
                        q_d     = DIV_Q_DBZ[WIDTH-1:0];
                        r_d     = a;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                dvd_d = dvd_q << 1;
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    q_d     = quo_nxt;
                    r_d     = rem_nxt[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working registers are only meaningful in CALC, so they carry no reset.
    always_ff @(posedge clk) begin
        dvd_q <= dvd_d;
        dsr_q <= dsr_d;
        rem_q <= rem_d;
        quo_q <= quo_d;
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;

endmodule
